// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU control path: widths, one-hot T states and
// default control-bit positions of the deferred writeback targets.
package cpu_ctrl_pkg;

    localparam int unsigned CTRL_W   = 67;
    localparam int unsigned T_W      = 7;
    localparam int unsigned NUM_DEST = 3;
    localparam int unsigned NUM_FLAG = 3;
    localparam int unsigned POS_W    = 8;

    // One-hot T states
    localparam logic [T_W-1:0] T0 = 7'b0000001;
    localparam logic [T_W-1:0] T1 = 7'b0000010;
    localparam logic [T_W-1:0] T2 = 7'b0000100;
    localparam logic [T_W-1:0] T3 = 7'b0001000;
    localparam logic [T_W-1:0] T4 = 7'b0010000;
    localparam logic [T_W-1:0] T5 = 7'b0100000;
    localparam logic [T_W-1:0] T6 = 7'b1000000;

    // Destination latch enables (special bus -> AC/X/Y)
    localparam logic [POS_W-1:0] SB_AC = 8'd10;
    localparam logic [POS_W-1:0] SB_X  = 8'd11;
    localparam logic [POS_W-1:0] SB_Y  = 8'd12;

    // Flag-source selects
    localparam logic [POS_W-1:0] FLAG_ALU = 8'd40;
    localparam logic [POS_W-1:0] FLAG_DB  = 8'd41;
    localparam logic [POS_W-1:0] FLAG_DBZ = 8'd42;

    // Packed position tables, entry 0 in the low byte
    localparam logic [NUM_DEST*POS_W-1:0] DEST_POS_DEF = {SB_Y, SB_X, SB_AC};
    localparam logic [NUM_FLAG*POS_W-1:0] FLAG_POS_DEF = {FLAG_DBZ, FLAG_DB, FLAG_ALU};

endpackage

// File: rtl/t_state_counter.sv
// One-hot T-state sequencer: reload to T1, shift on advance, hold at the
// last state and raise a sticky overflow flag when an instruction overruns.
module t_state_counter #(
    parameter int unsigned T_W = cpu_ctrl_pkg::T_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           adv,
    input  logic           reload,
    output logic [T_W-1:0] tState,
    output logic           overflow
);
    import cpu_ctrl_pkg::*;

    localparam logic [T_W-1:0] T_RELOAD = T_W'(2);

    logic [T_W-1:0] tNext;
    logic           overflowNext;

    // State register: T state and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            tState   <= T_RELOAD;
            overflow <= 1'b0;
        end else begin
            tState   <= tNext;
            overflow <= overflowNext;
        end
    end

    // Next state: reload wins, the last T state holds and flags an overrun
    always_comb begin
        tNext        = tState;
        overflowNext = overflow;
        if (adv) begin
            if (reload) begin
                tNext = T_RELOAD;
            end else if (tState[T_W-1]) begin
                overflowNext = 1'b1;
            end else begin
                tNext = tState << 1;
            end
        end
    end

endmodule

// File: rtl/ctrl_overlap_seq.sv
// Control-word register with overlapped writeback: destination/flag bits of a
// retiring instruction are deferred and OR-ed into the control word at T2 of
// the next instruction.
module ctrl_overlap_seq #(
    parameter int unsigned CTRL_W   = cpu_ctrl_pkg::CTRL_W,
    parameter int unsigned T_W      = cpu_ctrl_pkg::T_W,
    parameter int unsigned NUM_DEST = cpu_ctrl_pkg::NUM_DEST,
    parameter int unsigned NUM_FLAG = cpu_ctrl_pkg::NUM_FLAG,
    parameter logic [NUM_DEST*cpu_ctrl_pkg::POS_W-1:0] DEST_POS = cpu_ctrl_pkg::DEST_POS_DEF,
    parameter logic [NUM_FLAG*cpu_ctrl_pkg::POS_W-1:0] FLAG_POS = cpu_ctrl_pkg::FLAG_POS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic                rdy,
    input  logic                flush,
    input  logic [CTRL_W-1:0]   base_ctrl,
    input  logic [7:0]          op_in,
    input  logic                end_inst,
    input  logic [NUM_DEST-1:0] wb_dest,
    input  logic [NUM_FLAG-1:0] wb_flag,
    output logic [CTRL_W-1:0]   ctrl_out,
    output logic [T_W-1:0]      t_state,
    output logic [7:0]          prev_op,
    output logic                pend_valid,
    output logic                wb_fired,
    output logic                t_overflow
);
    import cpu_ctrl_pkg::*;

    logic                adv;
    logic                atT2;
    logic                applyNow;
    logic                captureNow;
    logic                reloadT;
    logic [NUM_DEST-1:0] pendDest;
    logic [NUM_FLAG-1:0] pendFlag;
    logic [CTRL_W-1:0]   wbMask;

    assign adv        = step & rdy;
    assign atT2       = t_state[2];
    assign applyNow   = adv & atT2 & pend_valid & ~flush;
    assign captureNow = adv & end_inst & ~flush;
    assign reloadT    = flush | end_inst;

    t_state_counter #(
        .T_W (T_W)
    ) u_tState (
        .clk      (clk),
        .rst      (rst),
        .adv      (adv),
        .reload   (reloadT),
        .tState   (t_state),
        .overflow (t_overflow)
    );

    // Writeback mask: only the positions named in the tables can ever be set
    always_comb begin
        wbMask = '0;
        for (int b = 0; b < int'(CTRL_W); b++) begin
            for (int i = 0; i < int'(NUM_DEST); i++) begin
                if (pendDest[i] && (DEST_POS[i*POS_W +: POS_W] == POS_W'(b))) begin
                    wbMask[b] = 1'b1;
                end
            end
            for (int j = 0; j < int'(NUM_FLAG); j++) begin
                if (pendFlag[j] && (FLAG_POS[j*POS_W +: POS_W] == POS_W'(b))) begin
                    wbMask[b] = 1'b1;
                end
            end
        end
    end

    // Control word, pending entry and retired-opcode registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_out   <= '0;
            prev_op    <= 8'h00;
            pend_valid <= 1'b0;
            pendDest   <= '0;
            pendFlag   <= '0;
            wb_fired   <= 1'b0;
        end else begin
            wb_fired <= applyNow;
            if (adv) begin
                ctrl_out <= applyNow ? (base_ctrl | wbMask) : base_ctrl;
            end
            // A capture in the apply step replaces the entry just consumed
            if (captureNow) begin
                pendDest   <= wb_dest;
                pendFlag   <= wb_flag;
                pend_valid <= (|wb_dest) | (|wb_flag);
                prev_op    <= op_in;
            end else if (applyNow || (adv && flush)) begin
                pendDest   <= '0;
                pendFlag   <= '0;
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_overlap_seq.sv
// Scoreboard bench for ctrl_overlap_seq: each directed vector pushes its
// hand-computed expected outputs; a monitor pops and compares after each edge.
module tb_ctrl_overlap_seq;

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    localparam logic [66:0] M_AC  = 67'h400;
    localparam logic [66:0] M_X   = 67'h800;
    localparam logic [66:0] M_Y   = 67'h1000;
    localparam logic [66:0] M_ALU = 67'h100_0000_0000;

    typedef struct packed {
        logic [66:0] ctrl;
        logic [6:0]  t;
        logic [7:0]  prevOp;
        logic        pend;
        logic        fired;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic        rdy;
    logic        flush;
    logic [66:0] base_ctrl;
    logic [7:0]  op_in;
    logic        end_inst;
    logic [2:0]  wb_dest;
    logic [2:0]  wb_flag;
    logic [66:0] ctrl_out;
    logic [6:0]  t_state;
    logic [7:0]  prev_op;
    logic        pend_valid;
    logic        wb_fired;
    logic        t_overflow;

    exp_t expQ[$];
    exp_t want;
    exp_t got;
    int   nCompared   = 0;
    int   nMismatched = 0;
    int   vecIdx      = 0;

    ctrl_overlap_seq dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .rdy        (rdy),
        .flush      (flush),
        .base_ctrl  (base_ctrl),
        .op_in      (op_in),
        .end_inst   (end_inst),
        .wb_dest    (wb_dest),
        .wb_flag    (wb_flag),
        .ctrl_out   (ctrl_out),
        .t_state    (t_state),
        .prev_op    (prev_op),
        .pend_valid (pend_valid),
        .wb_fired   (wb_fired),
        .t_overflow (t_overflow)
    );

    always #5 clk = ~clk;

    // Drive one vector on the falling edge and queue its expected outputs
    task automatic vec(input logic r, input logic s, input logic rd, input logic fl,
                       input logic en, input logic [2:0] d, input logic [2:0] f,
                       input logic [7:0] op, input logic [66:0] base,
                       input logic [66:0] eCtrl, input logic [6:0] eT, input logic [7:0] ePrev,
                       input logic ePend, input logic eFired, input logic eOvf);
        exp_t e;
        @(negedge clk);
        rst       = r;
        step      = s;
        rdy       = rd;
        flush     = fl;
        end_inst  = en;
        wb_dest   = d;
        wb_flag   = f;
        op_in     = op;
        base_ctrl = base;
        e.ctrl    = eCtrl;
        e.t       = eT;
        e.prevOp  = ePrev;
        e.pend    = ePend;
        e.fired   = eFired;
        e.ovf     = eOvf;
        expQ.push_back(e);
    endtask

    // Monitor: compare the registered outputs just after each active edge
    always @(posedge clk) begin
        #1;
        if (expQ.size() != 0) begin
            want = expQ.pop_front();
            got  = {ctrl_out, t_state, prev_op, pend_valid, wb_fired, t_overflow};
            nCompared++;
            if (got !== want) begin
                nMismatched++;
                $display("FAIL vec%0d: got ctrl=%h t=%h prev=%h pend=%b fired=%b ovf=%b, want ctrl=%h t=%h prev=%h pend=%b fired=%b ovf=%b",
                         vecIdx, got.ctrl, got.t, got.prevOp, got.pend, got.fired, got.ovf,
                         want.ctrl, want.t, want.prevOp, want.pend, want.fired, want.ovf);
            end
            vecIdx++;
        end
    end

    initial begin
        logic [6:0] tSeq [7];
        tSeq = '{7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h40, 7'h40};
        rst = 1'b1; step = 1'b0; rdy = 1'b1; flush = 1'b0; end_inst = 1'b0;
        wb_dest = 3'b000; wb_flag = 3'b000; op_in = 8'h00; base_ctrl = 67'h0;

        // Reset dominates step/end_inst
        vec(I,I,I,O,I, 3'b111,3'b111, 8'hFF, 67'h1,   67'h0,   7'h02, 8'h00, O,O,O);

        // Plain sequencing, pass-through of base_ctrl
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h123, 67'h123, 7'h04, 8'h00, O,O,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'hABC, 67'hABC, 7'h08, 8'h00, O,O,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h0,   67'h0,   7'h10, 8'h00, O,O,O);

        // INX-class: X latch deferred to next T2
        vec(O,I,I,O,I, 3'b010,3'b000, 8'hE8, 67'h5,   67'h5,   7'h02, 8'hE8, I,O,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h0,   67'h0,   7'h04, 8'hE8, I,O,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h0,   M_X,     7'h08, 8'hE8, O,I,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h7,   67'h7,   7'h10, 8'hE8, O,O,O);

        // INX-class with stalls between T1 and T2 (flush/end_inst ignored while stalled)
        vec(O,I,I,O,I, 3'b010,3'b000, 8'hE8, 67'h0,   67'h0,   7'h02, 8'hE8, I,O,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h0,   67'h0,   7'h04, 8'hE8, I,O,O);
        vec(O,I,O,O,O, 3'b000,3'b000, 8'h00, 67'hFFFF,67'h0,   7'h04, 8'hE8, I,O,O);
        vec(O,I,O,I,I, 3'b001,3'b000, 8'h77, 67'hFFFF,67'h0,   7'h04, 8'hE8, I,O,O);
        vec(O,I,O,O,O, 3'b000,3'b000, 8'h00, 67'hFFFF,67'h0,   7'h04, 8'hE8, I,O,O);
        vec(O,O,I,O,O, 3'b000,3'b000, 8'h00, 67'hFFFF,67'h0,   7'h04, 8'hE8, I,O,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h803, 67'h803, 7'h08, 8'hE8, O,I,O);

        // ADC-class, then end_inst at T2: apply old and capture new together
        vec(O,I,I,O,I, 3'b001,3'b001, 8'h69, 67'h0,   67'h0,   7'h02, 8'h69, I,O,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h0,   67'h0,   7'h04, 8'h69, I,O,O);
        vec(O,I,I,O,I, 3'b100,3'b000, 8'h6A, 67'h1,   67'h1 | M_AC | M_ALU, 7'h02, 8'h6A, I,I,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h0,   67'h0,   7'h04, 8'h6A, I,O,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h0,   M_Y,     7'h08, 8'h6A, O,I,O);

        // Flush at T2 with a pending AC entry
        vec(O,I,I,O,I, 3'b001,3'b000, 8'h65, 67'h0,   67'h0,   7'h02, 8'h65, I,O,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h0,   67'h0,   7'h04, 8'h65, I,O,O);
        vec(O,I,I,I,O, 3'b000,3'b000, 8'h00, 67'h55,  67'h55,  7'h02, 8'h65, O,O,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h0,   67'h0,   7'h04, 8'h65, O,O,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h0,   67'h0,   7'h08, 8'h65, O,O,O);
        // Flush together with end_inst captures nothing
        vec(O,I,I,I,I, 3'b111,3'b111, 8'h11, 67'h0,   67'h0,   7'h02, 8'h65, O,O,O);

        // Overrun: T holds at the last state and the sticky flag rises
        for (int k = 0; k < 7; k++) begin
            vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h0, 67'h0, tSeq[k], 8'h65, O,O,(k >= 5) ? I : O);
        end
        vec(O,I,I,O,I, 3'b000,3'b000, 8'h22, 67'h0,   67'h0,   7'h02, 8'h22, O,O,I);
        vec(O,I,I,O,I, 3'b010,3'b000, 8'h33, 67'h0,   67'h0,   7'h02, 8'h33, I,O,I);

        // Reset mid-instruction abandons the pending entry and clears the flag
        vec(I,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h9,   67'h0,   7'h02, 8'h00, O,O,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h0,   67'h0,   7'h04, 8'h00, O,O,O);
        vec(O,I,I,O,O, 3'b000,3'b000, 8'h00, 67'h0,   67'h0,   7'h08, 8'h00, O,O,O);

        // Drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 10 && expQ.size() != 0; w++) begin
            @(posedge clk);
            #2;
        end
        if (expQ.size() != 0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL drain: got %0d entries left, want 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
